// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator machine: field widths,
// sequencer states, instruction opcodes and the ALU operation map.
package cpu_pkg;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_OPERAND,
    ST_EXECUTE,
    ST_STORE,
    ST_HALT
  } state_t;

  // Which state follows DECODE for a given instruction
  typedef enum logic [1:0] {
    CLS_OPERAND,
    CLS_STORE,
    CLS_HALT,
    CLS_EXEC
  } cls_t;

  localparam logic [OPC_W-1:0] OP_HALT  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND   = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR    = 4'h6;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'h7;
  localparam logic [OPC_W-1:0] OP_MUL   = 4'h8;
  localparam logic [OPC_W-1:0] OP_CMPGT = 4'h9;
  localparam logic [OPC_W-1:0] OP_JUMP  = 4'hA;
  localparam logic [OPC_W-1:0] OP_SKIPZ = 4'hB;
  localparam logic [OPC_W-1:0] OP_SHL   = 4'hC;
  localparam logic [OPC_W-1:0] OP_SHR   = 4'hD;
  localparam logic [OPC_W-1:0] OP_LOADI = 4'hE;
  localparam logic [OPC_W-1:0] OP_NOP   = 4'hF;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_MUL   = 4'b0010;
  localparam logic [3:0] ALU_SHL   = 4'b0100;
  localparam logic [3:0] ALU_SHR   = 4'b0101;
  localparam logic [3:0] ALU_AND   = 4'b1000;
  localparam logic [3:0] ALU_OR    = 4'b1001;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_CMPGT = 4'b1110;
  localparam logic [3:0] ALU_NONE  = 4'b0000;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: next-state class, ALU operation and the
// operand-A zero force used by LOAD to pass memory data through the OR.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output logic [1:0]       o_cls,
  output logic [3:0]       o_alu_op,
  output logic             o_force_a_zero
);

  always_comb begin
    o_cls          = CLS_EXEC;
    o_alu_op       = ALU_NONE;
    o_force_a_zero = 1'b0;
    case (i_opcode)
      OP_HALT:  o_cls = CLS_HALT;
      OP_STORE: o_cls = CLS_STORE;
      OP_LOAD: begin
        o_cls          = CLS_OPERAND;
        o_alu_op       = ALU_OR;
        o_force_a_zero = 1'b1;
      end
      OP_ADD: begin
        o_cls    = CLS_OPERAND;
        o_alu_op = ALU_ADD;
      end
      OP_SUB: begin
        o_cls    = CLS_OPERAND;
        o_alu_op = ALU_SUB;
      end
      OP_AND: begin
        o_cls    = CLS_OPERAND;
        o_alu_op = ALU_AND;
      end
      OP_OR: begin
        o_cls    = CLS_OPERAND;
        o_alu_op = ALU_OR;
      end
      OP_XOR: begin
        o_cls    = CLS_OPERAND;
        o_alu_op = ALU_XOR;
      end
      OP_MUL: begin
        o_cls    = CLS_OPERAND;
        o_alu_op = ALU_MUL;
      end
      OP_CMPGT: begin
        o_cls    = CLS_OPERAND;
        o_alu_op = ALU_CMPGT;
      end
      OP_SHL: o_alu_op = ALU_SHL;
      OP_SHR: o_alu_op = ALU_SHR;
      OP_JUMP, OP_SKIPZ, OP_LOADI, OP_NOP: o_cls = CLS_EXEC;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator machine.
// Holds PC/IR/AC and drives the memory port and the combinational ALU.
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [3:0]        o_alu_opcode,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic              o_halted,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic [DATA_W-1:0] o_acc_out
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_ac;

  logic [OPC_W-1:0]    w_dec_opc;
  logic [1:0]          w_cls;
  logic [3:0]          w_alu_op;
  logic                w_force_a_zero;
  logic                w_in_exec;
  logic                w_mem_exec;
  logic [ADDR_W-1:0]   w_addr;

  // In DECODE the instruction is still on the memory bus, not yet in IR
  assign w_dec_opc = (r_state == ST_DECODE) ? i_mem_rdata[DATA_W-1 -: OPC_W]
                                            : r_ir[DATA_W-1 -: OPC_W];

  instr_decode u_decode (
    .i_opcode       (w_dec_opc),
    .o_cls          (w_cls),
    .o_alu_op       (w_alu_op),
    .o_force_a_zero (w_force_a_zero)
  );

  assign w_in_exec  = (r_state == ST_EXECUTE);
  assign w_mem_exec = w_in_exec && (w_cls == CLS_OPERAND);
  assign w_addr     = (r_state == ST_OPERAND || r_state == ST_STORE) ? r_ir[ADDR_W-1:0] : r_pc;

  assign o_mem_addr   = {{(DATA_W-ADDR_W){1'b0}}, w_addr};
  assign o_mem_wdata  = r_ac;
  assign o_mem_we     = (r_state == ST_STORE);
  assign o_alu_opcode = w_in_exec ? w_alu_op : ALU_NONE;
  assign o_alu_a      = (w_in_exec && w_force_a_zero) ? '0 : r_ac;
  assign o_alu_b      = w_mem_exec ? i_mem_rdata : '0;
  assign o_halted     = (r_state == ST_HALT);
  assign o_pc_out     = r_pc;
  assign o_acc_out    = r_ac;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_ac    <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (i_run) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_ir <= i_mem_rdata;
          r_pc <= pc_inc(r_pc);
          case (w_cls)
            CLS_OPERAND: r_state <= ST_OPERAND;
            CLS_STORE:   r_state <= ST_STORE;
            CLS_HALT:    r_state <= ST_HALT;
            default:     r_state <= ST_EXECUTE;
          endcase
        end
        ST_OPERAND: r_state <= ST_EXECUTE;
        ST_EXECUTE: begin
          r_state <= ST_FETCH;
          // Everything not listed here takes the ALU result
          case (r_ir[DATA_W-1 -: OPC_W])
            OP_JUMP:  r_pc <= r_ir[ADDR_W-1:0];
            OP_SKIPZ: if (r_ac == '0) r_pc <= pc_inc(r_pc);
            OP_LOADI: r_ac <= {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
            OP_NOP:   ;
            default:  r_ac <= i_alu_result;
          endcase
        end
        ST_STORE: r_state <= ST_FETCH;
        ST_HALT:  r_state <= ST_HALT;
        default:  r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: memory and ALU models around the DUT,
// and an instruction-level reference interpreter checked at every cycle phase.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b1;
  logic        load = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result, acc_out;
  logic        mem_we, halted;
  logic [3:0]  alu_opcode;
  logic [11:0] pc_out;

  logic [15:0] ram   [4096];
  logic [15:0] img   [4096];
  logic [15:0] m_mem [4096];
  int          we_cnt = 0;
  int          we_base;
  int          total = 0;
  int          bad = 0;

  logic [11:0] m_pc;
  logic [15:0] m_ac;
  bit          m_halt;
  int          m_stores;

  always #5 clk = ~clk;

  control_unit #(.RESET_PC(12'h000)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_run        (run),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_we     (mem_we),
    .i_mem_rdata  (mem_rdata),
    .o_alu_opcode (alu_opcode),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .i_alu_result (alu_result),
    .o_halted     (halted),
    .o_pc_out     (pc_out),
    .o_acc_out    (acc_out)
  );

  // Synchronous RAM with registered read data and a one-cycle bulk image load
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 4096; i++) ram[i] <= img[i];
    end else if (mem_we) begin
      ram[mem_addr[11:0]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[11:0]];
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  always_comb begin
    case (alu_opcode)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a * alu_b;
      4'b0100: alu_result = alu_a << 1;
      4'b0101: alu_result = alu_a >> 1;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      4'b1110: alu_result = (alu_a > alu_b) ? 16'd1 : 16'd0;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_alu(input logic [3:0] op);
    case (op)
      4'h1:    return 4'b1001;
      4'h3:    return 4'b0000;
      4'h4:    return 4'b0001;
      4'h5:    return 4'b1000;
      4'h6:    return 4'b1001;
      4'h7:    return 4'b1010;
      4'h8:    return 4'b0010;
      4'h9:    return 4'b1110;
      4'hC:    return 4'b0100;
      4'hD:    return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  // Instruction-level interpreter: one call executes one whole instruction
  task automatic model_step(output int cyc, output logic [3:0] op,
                            output logic [11:0] a, output logic [15:0] v);
    logic [15:0] ir;
    ir   = m_mem[m_pc];
    op   = ir[15:12];
    a    = ir[11:0];
    v    = m_mem[a];
    m_pc = m_pc + 12'd1;
    cyc  = (op == 4'h1 || (op >= 4'h3 && op <= 4'h9)) ? 4 : 3;
    case (op)
      4'h0: begin m_halt = 1'b1; cyc = 2; end
      4'h1: m_ac = v;
      4'h2: begin m_mem[a] = m_ac; m_stores++; end
      4'h3: m_ac = m_ac + v;
      4'h4: m_ac = m_ac - v;
      4'h5: m_ac = m_ac & v;
      4'h6: m_ac = m_ac | v;
      4'h7: m_ac = m_ac ^ v;
      4'h8: m_ac = 16'((32'(m_ac) * 32'(v)) % 65536);
      4'h9: m_ac = (m_ac > v) ? 16'd1 : 16'd0;
      4'hA: m_pc = a;
      4'hB: if (m_ac == 16'h0) m_pc = m_pc + 12'd1;
      4'hC: m_ac = 16'((32'(m_ac) * 2) % 65536);
      4'hD: m_ac = m_ac / 16'd2;
      4'hE: m_ac = {4'h0, a};
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_aluop", 32'(alu_opcode), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_b", 32'(alu_b), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_acc", 32'(acc_out), 32'h0);
    rst = 1'b0;
    m_mem = img;
    m_pc = 12'h000;
    m_ac = 16'h0000;
    m_halt = 1'b0;
    m_stores = 0;
    we_base = we_cnt;
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at the next FETCH/HALT
  task automatic step_check();
    int cyc;
    logic [3:0] op;
    logic [11:0] a;
    logic [15:0] v, ac0;
    if ($urandom_range(0, 3) == 0) begin
      run = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk("stall_addr", 32'(mem_addr), 32'({4'h0, m_pc}));
        chk("stall_pc", 32'(pc_out), 32'(m_pc));
      end
    end
    run = 1'b1;
    chk("fetch_addr", 32'(mem_addr), 32'({4'h0, m_pc}));
    chk("fetch_we", 32'(mem_we), 32'h0);
    ac0 = m_ac;
    model_step(cyc, op, a, v);
    @(negedge clk);
    chk("decode_we", 32'(mem_we), 32'h0);
    run = 1'($urandom_range(0, 1));
    if (cyc == 4) begin
      @(negedge clk);
      chk("operand_addr", 32'(mem_addr), 32'({4'h0, a}));
      chk("operand_we", 32'(mem_we), 32'h0);
      @(negedge clk);
      chk("exec_aluop", 32'(alu_opcode), 32'(exp_alu(op)));
      chk("exec_alu_a", 32'(alu_a), (op == 4'h1) ? 32'h0 : 32'(ac0));
      chk("exec_alu_b", 32'(alu_b), 32'(v));
    end else if (cyc == 3) begin
      @(negedge clk);
      if (op == 4'h2) begin
        chk("store_we", 32'(mem_we), 32'h1);
        chk("store_addr", 32'(mem_addr), 32'({4'h0, a}));
        chk("store_wdata", 32'(mem_wdata), 32'(ac0));
      end else begin
        chk("exec_aluop", 32'(alu_opcode), 32'(exp_alu(op)));
        chk("exec_alu_b", 32'(alu_b), 32'h0);
        chk("exec_we", 32'(mem_we), 32'h0);
      end
    end
    @(negedge clk);
    chk("pc", 32'(pc_out), 32'(m_pc));
    chk("acc", 32'(acc_out), 32'(m_ac));
    chk("halted", 32'(halted), 32'(m_halt));
  endtask

  task automatic run_prog(input int max_instr);
    for (int n = 0; n < max_instr && !m_halt; n++) step_check();
  endtask

  task automatic finish_prog();
    int mism;
    if (m_halt) begin
      repeat (3) @(negedge clk);
      chk("halt_hold", 32'(halted), 32'h1);
      chk("halt_pc", 32'(pc_out), 32'(m_pc));
      chk("halt_we", 32'(mem_we), 32'h0);
    end
    chk("store_count", 32'(we_cnt - we_base), 32'(m_stores));
    mism = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== m_mem[i]) mism++;
    chk("mem_image", 32'(mism), 32'h0);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 4096; i++) img[i] = 16'h0000;
  endtask

  initial begin
    // LOADI 5; ADD [0x100]; STORE [0x101]; HALT with exact cycle timing
    clear_img();
    img[0] = 16'hE005; img[1] = 16'h3100; img[2] = 16'h2101; img[3] = 16'h0000;
    img[12'h100] = 16'h0007;
    do_reset();
    repeat (11) @(negedge clk);
    chk("p1_halted_at_11", 32'(halted), 32'h0);
    @(negedge clk);
    chk("p1_halted_at_12", 32'(halted), 32'h1);
    chk("p1_m101", 32'(ram[12'h101]), 32'h000C);
    chk("p1_we_once", 32'(we_cnt - we_base), 32'h1);
    chk("p1_acc", 32'(acc_out), 32'h000C);

    // LOAD/ADD wrap to zero, SKIPZ over a word, MUL 3x1
    clear_img();
    img[0] = 16'h1010; img[1] = 16'h3011; img[2] = 16'hB000; img[3] = 16'hE0FF;
    img[4] = 16'hE003; img[5] = 16'h8012; img[6] = 16'h0000;
    img[12'h010] = 16'hFFFF; img[12'h011] = 16'h0001; img[12'h012] = 16'h0001;
    do_reset();
    run_prog(2);
    chk("p2_wrap_zero", 32'(acc_out), 32'h0000);
    run_prog(10);
    chk("p2_acc", 32'(acc_out), 32'h0003);
    chk("p2_pc", 32'(pc_out), 32'h007);
    finish_prog();

    // JUMP 0xFFF onto a NOP wraps the fetch address to 0x000
    clear_img();
    img[0] = 16'hAFFF; img[12'hFFF] = 16'hF000;
    do_reset();
    run_prog(2);
    chk("p3_wrap_addr", 32'(mem_addr), 32'h0000);
    chk("p3_wrap_pc", 32'(pc_out), 32'h000);

    // SKIPZ at 0xFFF wraps and then skips: lands on 0x001
    clear_img();
    img[0] = 16'hAFFF; img[12'hFFF] = 16'hB000; img[1] = 16'h0000;
    do_reset();
    run_prog(5);
    chk("p3b_pc", 32'(pc_out), 32'h002);
    finish_prog();

    // SHL/SHR on 0x8001, CMPGT 5 > 3
    clear_img();
    img[0] = 16'h1020; img[1] = 16'hC000; img[2] = 16'h1020; img[3] = 16'hD000;
    img[4] = 16'hE005; img[5] = 16'h9021; img[6] = 16'h0000;
    img[12'h020] = 16'h8001; img[12'h021] = 16'h0003;
    do_reset();
    run_prog(2);
    chk("p4_shl", 32'(acc_out), 32'h0002);
    run_prog(2);
    chk("p4_shr", 32'(acc_out), 32'h4000);
    run_prog(5);
    chk("p4_cmpgt", 32'(acc_out), 32'h0001);
    finish_prog();

    // Reset asserted in the middle of a STORE cycle
    clear_img();
    img[0] = 16'hE055; img[1] = 16'h2200; img[2] = 16'h0000; img[12'h200] = 16'h1234;
    do_reset();
    run_prog(1);
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("p5_store_we", 32'(mem_we), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("p5_abort_we", 32'(mem_we), 32'h0);
    chk("p5_abort_addr", 32'(mem_addr), 32'h0000);
    chk("p5_abort_pc", 32'(pc_out), 32'h000);
    chk("p5_abort_acc", 32'(acc_out), 32'h0000);
    @(negedge clk);
    chk("p5_mem_kept", 32'(ram[12'h200]), 32'h1234);
    chk("p5_no_write", 32'(we_cnt - we_base), 32'h0);
    rst = 1'b0;
    chk("p5_next_addr", 32'(mem_addr), 32'h0000);

    // run held low for 10 cycles after reset, then released
    clear_img();
    img[0] = 16'hE007; img[1] = 16'h2300; img[2] = 16'h0000;
    run = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("p6_idle_addr", 32'(mem_addr), 32'h0000);
      chk("p6_idle_pc", 32'(pc_out), 32'h000);
      chk("p6_idle_we", 32'(we_cnt - we_base), 32'h0);
    end
    run_prog(5);
    chk("p6_m300", 32'(ram[12'h300]), 32'h0007);
    finish_prog();

    // Random memory images executed against the reference interpreter
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 4096; i++) img[i] = 16'($urandom);
      do_reset();
      run_prog(40);
      finish_prog();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator machine. It holds PC, IR and AC, drives the main memory port (address, write data, write enable) and the combinational ALU's opcode and operands, and consumes the memory's registered read data and the ALU result. It sits directly between main memory and the ALU inside the top-level computer.

## Interface
- RESET_PC, 12'h000: PC value loaded on reset.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- run  in  1  when low, the sequencer waits in FETCH (no memory access, no PC change).
- mem_addr  out  16  memory address, always {4'h0, 12-bit address}.
- mem_wdata  out  16  write data (= AC).
- mem_we  out  1  memory write enable.
- mem_rdata  in  16  memory read data, valid one cycle after mem_addr is presented with mem_we=0.
- alu_opcode  out  4  ALU operation select.
- alu_a  out  16  ALU operand1 (= AC).
- alu_b  out  16  ALU operand2 (= mem_rdata in EXECUTE, else 16'h0000).
- alu_result  in  16  combinational ALU result.
- halted  out  1  high while in HALT.
- pc_out  out  12  current PC (debug).
- acc_out  out  16  current AC (debug).

## Operation
- Instruction word: [15:12] opcode, [11:0] addr/imm.
- Opcodes: 0 HALT; 1 LOAD (AC=M[a]); 2 STORE (M[a]=AC); 3 ADD; 4 SUB; 5 AND; 6 OR; 7 XOR; 8 MUL; 9 CMPGT (AC = AC>M[a] ? 1 : 0) — all memory-operand ops; A JUMP (PC=a); B SKIPZ (PC=PC+1 if AC==0); C SHL; D SHR; E LOADI (AC = zero-extended imm); F NOP.
- ALU opcode map: ADD 0000, SUB 0001, MUL 0010, SHL 0100, SHR 0101, AND 1000, OR 1001, XOR 1010, CMPGT 1110, LOAD 1001 with alu_a forced to 0 (the OR passes mem_rdata through). alu_opcode is 0000 in all non-ALU states.
- States:
  - FETCH: mem_addr=PC, we=0. If run=1, go to DECODE.
  - DECODE: IR<=mem_rdata, PC<=PC+1.
    - Next state is OPERAND for opcodes 1,3–9.
    - Next state is STORE for opcode 2.
    - Next state is HALT for opcode 0.
    - Otherwise next state is EXECUTE.
  - OPERAND: mem_addr=IR[11:0], we=0, then go to EXECUTE.
  - EXECUTE: perform the op.
    - Memory ops: AC<=alu_result.
    - SHL/SHR: AC<=alu_result with alu_b=0.
    - LOADI, JUMP, SKIPZ: update AC or PC directly.
    - NOP: no change.
    - Then go to FETCH.
  - STORE: mem_addr=IR[11:0], mem_wdata=AC, we=1 for exactly this cycle, then go to FETCH.
  - HALT: absorbing; halted=1; no memory writes; exits only on reset.
- Arithmetic: all AC results truncated to 16 bits; PC is 12-bit and wraps 0xFFF→0x000, including the SKIPZ increment.
- mem_we, mem_addr, alu_opcode and halted are Moore outputs decoded from state/PC/IR only.

## Timing
- Reset values: state=FETCH, PC=RESET_PC, IR=0, AC=0, mem_we=0, mem_addr={4'h0,RESET_PC}, mem_wdata=0, alu_opcode=0000, alu_a=0, alu_b=0, halted=0.
- Reset asserted mid-instruction: all outputs return to reset values immediately (asynchronous). A STORE in progress is aborted with mem_we low.
- Cycles per instruction:
  - Memory-operand ops: 4 (FETCH, DECODE, OPERAND, EXECUTE).
  - STORE: 3.
  - Register ops, JUMP, SKIPZ, LOADI, NOP: 3.
  - HALT: 2 cycles to enter.
- run is sampled only in FETCH; deasserting it mid-instruction has no effect until the next FETCH.
- A STORE followed by a LOAD from the same address returns the new value: the write lands at the STORE edge, and the read is two or more cycles later.

## Structure
- Shared package cpu_pkg:
  - state enum;
  - 4-bit instruction opcode constants;
  - ALU opcode constants, shared with the ALU;
  - field widths (OPC_W=4, ADDR_W=12, DATA_W=16).
- One sub-module, instr_decode: combinational; maps IR[15:12] to {next-state class, alu_opcode, force_a_zero}.
- The sequencer FSM and the PC/IR/AC registers live in control_unit.

## Test plan
- Program LOADI 5; ADD [0x100] (M=7); STORE [0x101]; HALT → M[0x101]=0x000C, halted=1 after 12 cycles, mem_we high exactly 1 cycle.
- LOAD [0x10] (M=0xFFFF); ADD [0x11] (M=1) → AC=0x0000 (wraps); then SKIPZ skips the next word; AC=0x0003 via MUL 3×1 path checks alu_opcode=0010.
- JUMP 0xFFF with M[0xFFF]=NOP → next fetch address is 0x000 (PC wrap).
- SHL on AC=0x8001 → 0x0002; SHR on AC=0x8001 → 0x4000; CMPGT AC=5 vs M=3 → 1.
- Assert reset during the STORE cycle → mem_we drops the same cycle, memory unchanged, PC=RESET_PC, next mem_addr=RESET_PC.
- Hold run=0 for 10 cycles after reset → mem_addr stays at RESET_PC, PC unchanged, no writes; raise run → execution begins next cycle.
